// File: rtl/cmd_sequencer_pkg.sv
// Shared constants for the host command sequencer: FSM state encoding,
// opcode values and the default frame header byte.
package cmd_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_HUNT    = 4'd0,
    ST_OPC     = 4'd1,
    ST_ADDR    = 4'd2,
    ST_DHI     = 4'd3,
    ST_DLO     = 4'd4,
    ST_RD_LAT  = 4'd5,
    ST_TX_HI   = 4'd6,
    ST_TX_HI_W = 4'd7,
    ST_TX_LO   = 4'd8,
    ST_TX_LO_W = 4'd9
  } state_t;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h10;
  localparam logic [7:0] OP_STOP   = 8'h11;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/cmd_sequencer_timeout.sv
// Inter-byte timeout counter: cleared by every received byte, counts only
// while enabled, and flags expiry for one cycle when it reaches TIMEOUT-1.
module cmd_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Independent of clear, so a byte landing on the expiry cycle loses.
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/cmd_sequencer.sv
// Host command front-end: frames serial bytes into WRITE/READ/START/STOP
// commands, drives the config register port and returns read data over tx.
module cmd_sequencer #(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = cmd_sequencer_pkg::SYNC_BYTE,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      cfg_we,
  output logic [ADDR_W-1:0]         cfg_addr,
  output logic [15:0]               cfg_wdata,
  input  logic [15:0]               cfg_rdata,
  output logic                      corr_start,
  output logic                      corr_stop,
  output logic [7:0]                tx_data,
  output logic                      tx_send,
  input  logic                      tx_busy,
  output logic                      err,
  output logic                      busy,
  output cmd_sequencer_pkg::state_t state
);
  import cmd_sequencer_pkg::*;

  state_t            state_nxt;
  logic              is_read, is_read_nxt;
  logic              rd_wait, rd_wait_nxt;
  logic [7:0]        dhi, dhi_nxt;
  logic [15:0]       hold, hold_nxt;
  logic              cfg_we_nxt, corr_start_nxt, corr_stop_nxt;
  logic              tx_send_nxt, err_nxt;
  logic [ADDR_W-1:0] cfg_addr_nxt;
  logic [15:0]       cfg_wdata_nxt;
  logic [7:0]        tx_data_nxt;
  logic              to_enable, to_expired;

  assign to_enable = (state == ST_OPC) || (state == ST_ADDR) ||
                     (state == ST_DHI) || (state == ST_DLO);
  assign busy      = (state != ST_HUNT);

  cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (to_enable),
    .expired (to_expired)
  );

  // tx handshake: tx_send is a one-cycle request with tx_data valid from then
  // on; tx_busy rises the next cycle and a new send is only made once it is low.
  always_comb begin
    state_nxt      = state;
    is_read_nxt    = is_read;
    rd_wait_nxt    = rd_wait;
    dhi_nxt        = dhi;
    hold_nxt       = hold;
    cfg_we_nxt     = 1'b0;
    corr_start_nxt = 1'b0;
    corr_stop_nxt  = 1'b0;
    tx_send_nxt    = 1'b0;
    err_nxt        = 1'b0;
    cfg_addr_nxt   = cfg_addr;
    cfg_wdata_nxt  = cfg_wdata;
    tx_data_nxt    = tx_data;
    if (to_expired) begin
      err_nxt   = 1'b1;
      state_nxt = ST_HUNT;
    end else begin
      case (state)
        ST_HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) state_nxt = ST_OPC;
        end
        ST_OPC: begin
          if (rx_valid) begin
            case (rx_data)
              OP_WRITE: begin is_read_nxt = 1'b0; state_nxt = ST_ADDR; end
              OP_READ:  begin is_read_nxt = 1'b1; state_nxt = ST_ADDR; end
              OP_START: begin corr_start_nxt = 1'b1; state_nxt = ST_HUNT; end
              OP_STOP:  begin corr_stop_nxt = 1'b1; state_nxt = ST_HUNT; end
              default:  begin err_nxt = 1'b1; state_nxt = ST_HUNT; end
            endcase
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            if ((rx_data >> ADDR_W) != 8'd0) begin
              err_nxt   = 1'b1;
              state_nxt = ST_HUNT;
            end else begin
              cfg_addr_nxt = rx_data[ADDR_W-1:0];
              rd_wait_nxt  = 1'b1;
              state_nxt    = is_read ? ST_RD_LAT : ST_DHI;
            end
          end
        end
        ST_DHI: begin
          if (rx_valid) begin
            dhi_nxt   = rx_data;
            state_nxt = ST_DLO;
          end
        end
        ST_DLO: begin
          if (rx_valid) begin
            cfg_wdata_nxt = {dhi, rx_data};
            cfg_we_nxt    = 1'b1;
            state_nxt     = ST_HUNT;
          end
        end
        ST_RD_LAT: begin
          // cfg_addr becomes valid on entry; the register file answers a cycle later.
          if (rd_wait) begin
            rd_wait_nxt = 1'b0;
          end else begin
            hold_nxt  = cfg_rdata;
            state_nxt = ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          if (!tx_busy) begin
            tx_data_nxt = hold[15:8];
            tx_send_nxt = 1'b1;
            state_nxt   = ST_TX_HI_W;
          end
        end
        ST_TX_HI_W: begin
          if (!tx_send && !tx_busy) state_nxt = ST_TX_LO;
        end
        ST_TX_LO: begin
          if (!tx_busy) begin
            tx_data_nxt = hold[7:0];
            tx_send_nxt = 1'b1;
            state_nxt   = ST_TX_LO_W;
          end
        end
        ST_TX_LO_W: begin
          if (!tx_send && !tx_busy) state_nxt = ST_HUNT;
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_HUNT;
      is_read    <= 1'b0;
      rd_wait    <= 1'b0;
      dhi        <= '0;
      hold       <= '0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      corr_start <= 1'b0;
      corr_stop  <= 1'b0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      is_read    <= is_read_nxt;
      rd_wait    <= rd_wait_nxt;
      dhi        <= dhi_nxt;
      hold       <= hold_nxt;
      cfg_we     <= cfg_we_nxt;
      cfg_addr   <= cfg_addr_nxt;
      cfg_wdata  <= cfg_wdata_nxt;
      corr_start <= corr_start_nxt;
      corr_stop  <= corr_stop_nxt;
      tx_data    <= tx_data_nxt;
      tx_send    <= tx_send_nxt;
      err        <= err_nxt;
    end
  end

endmodule
